// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring divide. Define ALU_STATUS_FLAGS_EN to add carry/overflow outputs.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [WIDTH-1:0] r_opa, w_opa_nx;
    logic [WIDTH-1:0] r_opb, w_opb_nx;
    logic [WIDTH-1:0] r_hi, w_hi_nx;
    logic [WIDTH-1:0] r_lo, w_lo_nx;
    logic [WIDTH-1:0] r_result, w_result_nx;
    logic [WIDTH-1:0] r_result_hi, w_result_hi_nx;
    logic             r_zero, w_zero_nx;
    logic             r_dbz, w_dbz_nx;
    logic             r_done, w_done_nx;

    // Completion request: w_ld writes new results, w_hold only pulses done.
    logic             w_ld, w_hold, w_ld_dbz;
    logic [WIDTH-1:0] w_ld_res, w_ld_hi;

    logic [WIDTH-1:0] w_add, w_sub;

`ifdef ALU_STATUS_FLAGS_EN
    logic r_carry, w_carry_nx;
    logic r_ovf, w_ovf_nx;
    logic w_ld_c, w_ld_v;
    logic w_add_c, w_add_v, w_sub_c, w_sub_v;

    assign {w_add_c, w_add} = {1'b0, a} + {1'b0, b};
    assign w_sub   = a - b;
    assign w_sub_c = (a < b);
    assign w_add_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
`else
    assign w_add = a + b;
    assign w_sub = a - b;
`endif

    // Multiply: r_hi accumulates, r_lo holds the multiplier and collects low product bits.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]   w_div_shift, w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_hi, w_div_lo;

    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_div_hi    = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_opa_nx       = r_opa;
        w_opb_nx       = r_opb;
        w_hi_nx        = r_hi;
        w_lo_nx        = r_lo;
        w_result_nx    = r_result;
        w_result_hi_nx = r_result_hi;
        w_zero_nx      = r_zero;
        w_dbz_nx       = r_dbz;
        w_done_nx      = 1'b0;
        w_ld           = 1'b0;
        w_hold         = 1'b0;
        w_ld_dbz       = 1'b0;
        w_ld_res       = '0;
        w_ld_hi        = '0;
`ifdef ALU_STATUS_FLAGS_EN
        w_carry_nx     = r_carry;
        w_ovf_nx       = r_ovf;
        w_ld_c         = 1'b0;
        w_ld_v         = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (operation)
                        OP_ADD: begin
                            w_ld     = 1'b1;
                            w_ld_res = w_add;
`ifdef ALU_STATUS_FLAGS_EN
                            w_ld_c   = w_add_c;
                            w_ld_v   = w_add_v;
`endif
                        end
                        OP_SUB, OP_CMP: begin
                            w_ld     = 1'b1;
                            w_ld_res = w_sub;
`ifdef ALU_STATUS_FLAGS_EN
                            w_ld_c   = w_sub_c;
                            w_ld_v   = w_sub_v;
`endif
                        end
                        OP_MOVE: begin
                            w_ld     = 1'b1;
                            w_ld_res = a;
                        end
                        OP_SWAP: begin
                            w_ld     = 1'b1;
                            w_ld_res = b;
                            w_ld_hi  = a;
                        end
                        OP_AND: begin
                            w_ld     = 1'b1;
                            w_ld_res = a & b;
                        end
                        OP_OR: begin
                            w_ld     = 1'b1;
                            w_ld_res = a | b;
                        end
                        OP_MUL: begin
                            w_state_nx = S_MUL;
                            w_cnt_nx   = '0;
                            w_opa_nx   = a;
                            w_hi_nx    = '0;
                            w_lo_nx    = b;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                w_ld     = 1'b1;
                                w_ld_res = '1;
                                w_ld_hi  = a;
                                w_ld_dbz = 1'b1;
                            end else begin
                                w_state_nx = S_DIV;
                                w_cnt_nx   = '0;
                                w_opb_nx   = b;
                                w_hi_nx    = '0;
                                w_lo_nx    = a;
                            end
                        end
                        default: w_hold = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                w_hi_nx = w_mul_hi;
                w_lo_nx = w_mul_lo;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_ld       = 1'b1;
                    w_ld_res   = w_mul_lo;
                    w_ld_hi    = w_mul_hi;
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_DIV: begin
                w_hi_nx = w_div_hi;
                w_lo_nx = w_div_lo;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_ld       = 1'b1;
                    w_ld_res   = w_div_lo;
                    w_ld_hi    = w_div_hi;
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        if (w_ld) begin
            w_result_nx    = w_ld_res;
            w_result_hi_nx = w_ld_hi;
            w_zero_nx      = (w_ld_res == '0);
            w_dbz_nx       = w_ld_dbz;
            w_done_nx      = 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
            w_carry_nx     = w_ld_c;
            w_ovf_nx       = w_ld_v;
`endif
        end else if (w_hold) begin
            // Jump/halt and unused codes keep result and zero for the branch logic.
            w_dbz_nx       = 1'b0;
            w_done_nx      = 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
            w_carry_nx     = 1'b0;
            w_ovf_nx       = 1'b0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_opa       <= w_opa_nx;
            r_opb       <= w_opb_nx;
            r_hi        <= w_hi_nx;
            r_lo        <= w_lo_nx;
            r_result    <= w_result_nx;
            r_result_hi <= w_result_hi_nx;
            r_zero      <= w_zero_nx;
            r_dbz       <= w_dbz_nx;
            r_done      <= w_done_nx;
`ifdef ALU_STATUS_FLAGS_EN
            r_carry     <= w_carry_nx;
            r_ovf       <= w_ovf_nx;
`endif
        end
    end

    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);
`ifdef ALU_STATUS_FLAGS_EN
    assign carry       = r_carry;
    assign overflow    = r_ovf;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literals.
module tb_alu_multicycle;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   operation = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, result_hi;
    logic         zero, div_by_zero, busy, done;
`ifdef ALU_STATUS_FLAGS_EN
    logic         carry, overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .operation(operation),
        .a(a),
        .b(b),
        .result(result),
        .result_hi(result_hi),
        .zero(zero),
        .div_by_zero(div_by_zero),
        .busy(busy),
        .done(done)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .carry(carry),
        .overflow(overflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic         lng;
        logic         hold;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         dbz;
        logic         c;
        logic         v;
    } exp_t;

    function automatic exp_t model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint ux, uy, sx, sy, s, smax, smin, p;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        e.lng = 1'b0; e.hold = 1'b0; e.res = '0; e.hi = '0; e.dbz = 1'b0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            4'b0001: begin
                e.res = W'(ux + uy);
                e.c   = (ux + uy) >= (longint'(1) << W);
                s     = sx + sy;
                e.v   = (s > smax) || (s < smin);
            end
            4'b0010, 4'b1001: begin
                e.res = W'(ux - uy);
                e.c   = ux < uy;
                s     = sx - sy;
                e.v   = (s > smax) || (s < smin);
            end
            4'b0011: begin
                p     = ux * uy;
                e.lng = 1'b1;
                e.res = W'(p);
                e.hi  = W'(p >> W);
            end
            4'b0100: begin
                if (uy == 0) begin
                    e.res = '1;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else begin
                    e.lng = 1'b1;
                    e.res = W'(ux / uy);
                    e.hi  = W'(ux % uy);
                end
            end
            4'b0101: e.res = x;
            4'b0110: begin e.res = y; e.hi = x; end
            4'b0111: e.res = x & y;
            4'b1000: e.res = x | y;
            default: e.hold = 1'b1;
        endcase
        return e;
    endfunction

    exp_t         m_now, m_pend;
    logic [W-1:0] m_res, m_hi;
    logic         m_zero, m_dbz, m_done, m_c, m_v;
    int           m_cnt;

    always_comb m_now = model_op(operation, a, b);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res <= '0; m_hi <= '0; m_zero <= 1'b0; m_dbz <= 1'b0;
            m_done <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_res <= m_pend.res; m_hi <= m_pend.hi; m_zero <= (m_pend.res == '0);
                    m_dbz <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_done <= 1'b1;
                end
            end else if (start) begin
                if (m_now.lng) begin
                    m_cnt  <= W;
                    m_pend <= m_now;
                end else if (m_now.hold) begin
                    m_dbz <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_res <= m_now.res; m_hi <= m_now.hi; m_zero <= (m_now.res == '0);
                    m_dbz <= m_now.dbz; m_c <= m_now.c; m_v <= m_now.v; m_done <= 1'b1;
                end
            end
        end
    end

    // Outputs are registered and always meaningful, so compare on every falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("done", done, m_done);
            check("busy", busy, m_cnt > 0);
            check("result", result, m_res);
            check("result_hi", result_hi, m_hi);
            check("zero", zero, m_zero);
            check("div_by_zero", div_by_zero, m_dbz);
`ifdef ALU_STATUS_FLAGS_EN
            check("carry", carry, m_c);
            check("overflow", overflow, m_v);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start     = 1'b1;
        operation = op;
        a         = x;
        b         = y;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input int from, input int limit, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < limit) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs[12] = '{
        '{4'b0001, 16'hFFFF, 16'h0001},
        '{4'b0010, 16'h0000, 16'h0001},
        '{4'b0010, 16'h8000, 16'h0001},
        '{4'b0111, 16'hF0F0, 16'h0FF0},
        '{4'b1000, 16'hF0F0, 16'h0FF0},
        '{4'b0101, 16'h0000, 16'h1234},
        '{4'b0000, 16'h1111, 16'h2222},
        '{4'b0011, 16'hFFFF, 16'hFFFF},
        '{4'b0100, 16'h0003, 16'h000A},
        '{4'b0100, 16'hFFFF, 16'h0001},
        '{4'b1111, 16'h0001, 16'h0001},
        '{4'b0011, 16'h0000, 16'h5A5A}
    };

    initial begin
        int lat;

        // 1: asynchronous reset mid-cycle, before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_result", result, 16'h0);
        check("rst_result_hi", result_hi, 16'h0);
        check("rst_zero", zero, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        chk_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        idle(1);

        issue(4'b0001, 16'h7FFF, 16'h0001);
        check("add_done", done, 1'b1);
        check("add_result", result, 16'h8000);
        check("add_zero", zero, 1'b0);
        check("add_result_hi", result_hi, 16'h0);
`ifdef ALU_STATUS_FLAGS_EN
        check("add_overflow", overflow, 1'b1);
        check("add_carry", carry, 1'b0);
`endif

        // 2: back-to-back compares
        issue(4'b1001, 16'd5, 16'd5);
        check("cmp_eq_done", done, 1'b1);
        check("cmp_eq_zero", zero, 1'b1);
        issue(4'b1001, 16'd5, 16'd6);
        check("cmp_ne_done", done, 1'b1);
        check("cmp_ne_zero", zero, 1'b0);
        check("cmp_ne_result", result, 16'hFFFF);
        idle(1);

        // 3: multiply, with an ignored start and operand changes while busy
        issue(4'b0011, 16'h1234, 16'h0100);
        check("mul_busy", busy, 1'b1);
        start = 1'b1; operation = 4'b0001; a = 16'hFFFF; b = 16'h0FFF;
        @(posedge clk);
        #2;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        wait_done(1, 60, lat);
        check("mul_latency", lat, 16);
        check("mul_result_hi", result_hi, 16'h0012);
        check("mul_result", result, 16'h3400);
        check("mul_busy_done", busy, 1'b0);

        // 4: divide issued in the done cycle, then divide by zero
        issue(4'b0100, 16'd100, 16'd7);
        start = 1'b0;
        wait_done(0, 60, lat);
        check("div_latency", lat, 16);
        check("div_quot", result, 16'd14);
        check("div_rem", result_hi, 16'd2);
        check("div_dbz", div_by_zero, 1'b0);
        issue(4'b0100, 16'd9, 16'd0);
        check("dbz_done", done, 1'b1);
        check("dbz_result", result, 16'hFFFF);
        check("dbz_result_hi", result_hi, 16'd9);
        check("dbz_flag", div_by_zero, 1'b1);

        // 5: swap, then an unused op code holds results
        issue(4'b0110, 16'hAAAA, 16'h5555);
        check("swap_result", result, 16'h5555);
        check("swap_result_hi", result_hi, 16'hAAAA);
        check("swap_dbz", div_by_zero, 1'b0);
        issue(4'b1100, 16'h0001, 16'h0002);
        check("nop_done", done, 1'b1);
        check("nop_result", result, 16'h5555);
        check("nop_result_hi", result_hi, 16'hAAAA);
        idle(1);

        // extra vectors, checked against the model each cycle
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y);
            start = 1'b0;
            wait_done(0, 60, lat);
            idle(1);
        end
        check("mulmax_hi", result_hi, 16'h0000);
        issue(4'b0011, 16'hFFFF, 16'hFFFF);
        start = 1'b0;
        wait_done(0, 60, lat);
        check("mulmax_hi_lit", result_hi, 16'hFFFE);
        check("mulmax_lo_lit", result, 16'h0001);
        idle(1);

        // 6: reset mid-multiply
        issue(4'b0011, 16'd3, 16'd5);
        idle(7);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 16'h0);
        check("abort_result_hi", result_hi, 16'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(1);
        issue(4'b0001, 16'd2, 16'd3);
        start = 1'b0;
        check("post_rst_done", done, 1'b1);
        check("post_rst_result", result, 16'd5);
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
